// File: rtl/signed_divider_pkg.sv
// Shared definitions for the signed divider.
// Holds the control FSM state encoding and the fixed operand widths.
package signed_divider_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int ITER_COUNT = 8;
  localparam int CNT_W      = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    ITER  = 3'd3,
    FIX   = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/addsub.sv
// Combinational W-bit adder/subtractor cell.
// Ports:
//   a, b   : operands
//   sub    : 1 -> a - b, 0 -> a + b
//   result : low W bits of the result
//   carry  : carry out; when subtracting, 1 means no borrow (a >= b unsigned)
module addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         carry
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
  end

  assign result = full[W-1:0];
  assign carry  = full[W];

endmodule

// File: rtl/counter_down.sv
// Loadable W-bit down counter with synchronous active-high reset.
// Ports:
//   clk, reset : clock and synchronous reset
//   load       : load load_value (has priority over en)
//   en         : decrement by one
//   count      : current value
//   zero       : count == 0
module counter_down #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/div_datapath.sv
// Datapath of the signed divider: operand/magnitude registers, 9-bit
// restoring-division step, iteration counter, sign fix and result registers.
// Ports:
//   clk, reset             : clock and synchronous reset
//   capture                : latch raw operands (accepted start), clear results
//   load                   : record signs, replace operands by magnitudes
//   check                  : error screening; seeds the partial remainder
//   iter                   : one restoring-division step
//   fix                    : apply signs and signed-range check
//   dividend, divisor      : raw two's-complement operands
//   error                  : divide-by-zero or early overflow (valid in CHECK)
//   last                   : final iteration step in progress
//   quotient, remainder    : signed results
//   div_by_zero, overflow  : error flags
module div_datapath
  import signed_divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture,
  input  logic                  load,
  input  logic                  check,
  input  logic                  iter,
  input  logic                  fix,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  error,
  output logic                  last,
  output logic [DIVISOR_W-1:0]  quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  logic [DIVIDEND_W-1:0] dvd_reg;
  logic [DIVISOR_W-1:0]  dvs_reg;
  logic                  dvd_neg_reg;
  logic                  dvs_neg_reg;
  logic [DIVISOR_W-1:0]  part_reg;
  logic [DIVISOR_W-1:0]  quo_reg;
  logic [CNT_W-1:0]      count;

  logic [DIVIDEND_W-1:0] dvd_negated;
  logic [DIVISOR_W-1:0]  dvs_negated;
  logic [DIVISOR_W-1:0]  quo_negated;
  logic [DIVISOR_W-1:0]  rem_negated;
  logic [DIVISOR_W:0]    part_shift;
  logic [DIVISOR_W:0]    trial_diff;
  logic                  trial_ok;
  logic                  dbz_chk;
  logic                  ovf_chk;
  logic                  sign_diff;
  logic                  fix_ovf;
  logic [3:0]            unused_carry;

  // Magnitudes; |-32768| wraps to 0x8000, which is the correct unsigned value.
  addsub #(.W(DIVIDEND_W)) u_neg_dvd (
    .a(16'd0), .b(dvd_reg), .sub(1'b1), .result(dvd_negated), .carry(unused_carry[0])
  );
  addsub #(.W(DIVISOR_W)) u_neg_dvs (
    .a(8'd0), .b(dvs_reg), .sub(1'b1), .result(dvs_negated), .carry(unused_carry[1])
  );

  // Restoring step: shift {R,Q} left, trial-subtract |divisor| on 9 bits.
  // The carry out is the "no borrow" indication, i.e. difference non-negative.
  assign part_shift = {part_reg, quo_reg[DIVISOR_W-1]};
  addsub #(.W(DIVISOR_W + 1)) u_trial (
    .a(part_shift), .b({1'b0, dvs_reg}), .sub(1'b1), .result(trial_diff), .carry(trial_ok)
  );

  addsub #(.W(DIVISOR_W)) u_neg_quo (
    .a(8'd0), .b(quo_reg), .sub(1'b1), .result(quo_negated), .carry(unused_carry[2])
  );
  addsub #(.W(DIVISOR_W)) u_neg_rem (
    .a(8'd0), .b(part_reg), .sub(1'b1), .result(rem_negated), .carry(unused_carry[3])
  );

  counter_down #(.W(CNT_W)) u_count (
    .clk(clk), .reset(reset), .load(check), .load_value(CNT_W'(ITER_COUNT - 1)),
    .en(iter), .count(count), .zero(last)
  );

  // In CHECK the operand registers already hold magnitudes. An upper dividend
  // byte >= divisor means the magnitude quotient needs more than 8 bits.
  assign dbz_chk = (dvs_reg == '0);
  assign ovf_chk = (dvd_reg[DIVIDEND_W-1:DIVISOR_W] >= dvs_reg);
  assign error   = dbz_chk | ovf_chk;

  // -128 is representable only when the result is negative.
  assign sign_diff = dvd_neg_reg ^ dvs_neg_reg;
  assign fix_ovf   = sign_diff ? (quo_reg > 8'd128) : (quo_reg > 8'd127);

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      dvd_neg_reg <= 1'b0;
      dvs_neg_reg <= 1'b0;
      part_reg    <= '0;
      quo_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (capture) begin
        dvd_reg     <= dividend;
        dvs_reg     <= divisor;
        quotient    <= '0;
        remainder   <= '0;
        div_by_zero <= 1'b0;
        overflow    <= 1'b0;
      end
      if (load) begin
        dvd_neg_reg <= dvd_reg[DIVIDEND_W-1];
        dvs_neg_reg <= dvs_reg[DIVISOR_W-1];
        dvd_reg     <= dvd_reg[DIVIDEND_W-1] ? dvd_negated : dvd_reg;
        dvs_reg     <= dvs_reg[DIVISOR_W-1] ? dvs_negated : dvs_reg;
      end
      if (check) begin
        part_reg <= dvd_reg[DIVIDEND_W-1:DIVISOR_W];
        quo_reg  <= dvd_reg[DIVISOR_W-1:0];
        if (error) begin
          div_by_zero <= dbz_chk;
          overflow    <= ~dbz_chk & ovf_chk;
          quotient    <= '0;
          remainder   <= '0;
        end
      end
      if (iter) begin
        // The kept partial remainder is always < |divisor|, so 8 bits suffice.
        part_reg <= trial_ok ? trial_diff[DIVISOR_W-1:0] : part_shift[DIVISOR_W-1:0];
        quo_reg  <= {quo_reg[DIVISOR_W-2:0], trial_ok};
      end
      if (fix) begin
        div_by_zero <= 1'b0;
        overflow    <= fix_ovf;
        quotient    <= fix_ovf ? '0 : (sign_diff ? quo_negated : quo_reg);
        remainder   <= fix_ovf ? '0 : (dvd_neg_reg ? rem_negated : part_reg);
      end
    end
  end

endmodule

// File: rtl/signed_divider.sv
// 16-bit by 8-bit signed divider (truncating toward zero), multi-cycle.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   start                 : request a division, sampled only in IDLE
//   dividend, divisor     : two's-complement operands, sampled with start
//   quotient, remainder   : signed results, valid from done to next start
//   busy                  : high in every state except IDLE
//   done                  : one-cycle completion pulse
//   div_by_zero, overflow : error flags, held until the next start
module signed_divider
  import signed_divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVISOR_W-1:0]  quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic                  overflow
);

  state_t state;
  logic   error;
  logic   last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD:  state <= CHECK;
        CHECK: begin
          if (error) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= ITER;
          end
        end
        ITER:  if (last) state <= FIX;
        FIX: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  div_datapath u_datapath (
    .clk        (clk),
    .reset      (reset),
    .capture    (state == IDLE && start),
    .load       (state == LOAD),
    .check      (state == CHECK),
    .iter       (state == ITER),
    .fix        (state == FIX),
    .dividend   (dividend),
    .divisor    (divisor),
    .error      (error),
    .last       (last),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_signed_divider.sv
// Directed self-checking bench for signed_divider.
module tb_signed_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  signed_divider dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One division: start sampled at edge N; lat counts edges until done is seen.
  // hold keeps start high (with junk operands) for that many cycles after acceptance.
  task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input logic eov, input int elat, input int hold);
    int lat;
    @(posedge clk); #1;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = (hold > 0); dividend = 16'hA5A5; divisor = 8'h5A;
    lat = 0;
    check({tag, ".busy"}, busy, 1);
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat >= hold) start = 1'b0;
    end
    check({tag, ".latency"}, lat, elat);
    check({tag, ".quotient"}, quotient, eq);
    check({tag, ".remainder"}, remainder, er);
    check({tag, ".div_by_zero"}, div_by_zero, edz);
    check({tag, ".overflow"}, overflow, eov);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".idle"}, busy, 0);
    check({tag, ".held_q"}, quotient, eq);
    $display("txn %s: a=0x%04h b=0x%02h q=0x%02h r=0x%02h dz=%0b ov=%0b lat=%0d",
             tag, a, b, quotient, remainder, div_by_zero, overflow, lat);
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b1; dividend = 16'd100; divisor = 8'd7;
    repeat (3) @(posedge clk);
    #1;
    // Reset has priority over a concurrent start.
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.quotient", quotient, 0);
    check("rst.remainder", remainder, 0);
    check("rst.div_by_zero", div_by_zero, 0);
    check("rst.overflow", overflow, 0);
    reset = 1'b0; start = 1'b0;

    run_div("100/7",      16'd100,   8'd7,    8'h0E, 8'h02, 0, 0, 11, 0);
    run_div("-100/7",     16'hFF9C,  8'd7,    8'hF2, 8'hFE, 0, 0, 11, 0);
    run_div("100/-7",     16'd100,   8'hF9,   8'hF2, 8'h02, 0, 0, 11, 0);
    run_div("-1024/8",    16'hFC00,  8'd8,    8'h80, 8'h00, 0, 0, 11, 0);
    run_div("-1024/-8",   16'hFC00,  8'hF8,   8'h00, 8'h00, 0, 1, 11, 0);
    run_div("1234/0",     16'd1234,  8'd0,    8'h00, 8'h00, 1, 0, 2,  0);
    run_div("32767/1",    16'd32767, 8'd1,    8'h00, 8'h00, 0, 1, 2,  0);
    run_div("-32768/-128",16'h8000,  8'h80,   8'h00, 8'h00, 0, 1, 2,  0);
    run_div("-16384/-128",16'hC000,  8'h80,   8'h00, 8'h00, 0, 1, 11, 0);
    run_div("16256/-128", 16'd16256, 8'h80,   8'h81, 8'h00, 0, 0, 11, 4);
    run_div("-21/7",      16'hFFEB,  8'd7,    8'hFD, 8'h00, 0, 0, 11, 0);
    run_div("-7/100",     16'hFFF9,  8'd100,  8'h00, 8'hF9, 0, 0, 11, 0);
    run_div("7/100",      16'd7,     8'd100,  8'h00, 8'h07, 0, 0, 11, 3);

    // Reset in the 4th ITER cycle aborts with no done pulse.
    @(posedge clk); #1;
    start = 1'b1; dividend = 16'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort.busy_before", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.quotient", quotient, 0);
    check("abort.remainder", remainder, 0);
    check("abort.flags", {div_by_zero, overflow}, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check("abort.no_done", seen, 0);
    $display("txn abort: reset during ITER, done pulses seen=%0d", seen);

    run_div("100/7 again", 16'd100, 8'd7, 8'h0E, 8'h02, 0, 0, 11, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/signed_divider.md
SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 16-bit dividend and 8-bit divisor, quotient and remainder.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: ports clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a division; sampled only in IDLE.
REQ-006 dividend  input  16  two's-complement dividend; sampled with start.
REQ-007 divisor  input  8  two's-complement divisor; sampled with start.
REQ-008 quotient  output  8  two's-complement quotient; valid from done until the next accepted start.
REQ-009 remainder  output  8  two's-complement remainder; valid from done until the next accepted start.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse, high only in the DONE state.
REQ-012 div_by_zero  output  1  error flag; updated at DONE and held until the next accepted start.
REQ-013 overflow  output  1  error flag; true quotient is outside -128..127; updated at DONE and held until the next accepted start.

Function
REQ-014 Arithmetic: truncating division toward zero; dividend = quotient*divisor + remainder; |remainder| < |divisor|; remainder takes the sign of the dividend (0 when exact).
REQ-015 FSM states and transitions:
- IDLE -> LOAD when start=1.
- LOAD -> CHECK.
- CHECK -> DONE on error, otherwise -> ITER.
- ITER -> ITER for 8 cycles total, then -> FIX.
- FIX -> DONE.
- DONE -> IDLE.
REQ-016 LOAD: capture the operand signs; replace both operands by their 16-bit and 8-bit magnitudes (|-32768| = 32768 unsigned).
REQ-017 CHECK, divide by zero: |divisor| = 0 -> div_by_zero=1.
REQ-018 CHECK, overflow: |dividend|[15:8] >= |divisor| (magnitude quotient >= 256) -> overflow=1.
REQ-019 ITER: unsigned restoring step on a 9-bit partial remainder.
- Shift left the {R,Q} pair.
- Trial-subtract |divisor|.
- If non-negative: keep the difference, set the quotient bit to 1.
- Otherwise: restore, set the quotient bit to 0.
- A 3-bit down counter tracks the 8 steps.
REQ-020 FIX, quotient sign: negate the magnitude quotient when the operand signs differ; negate the remainder when the dividend is negative.
REQ-021 FIX, signed range: overflow=1 when the signs are equal and the magnitude quotient > 127, or when the signs differ and the magnitude quotient > 128.
REQ-022 Latency, normal case: start sampled at edge N -> done high in the cycle after edge N+11.
REQ-023 Latency, error case: done high in the cycle after edge N+2.
REQ-024 On either error flag, quotient=0 and remainder=0.
REQ-025 start while busy SHALL be ignored; it is neither queued nor does it corrupt the operation in flight.
REQ-026 start high in DONE SHALL be ignored; a start held high is accepted on the first IDLE cycle.
REQ-027 The operand inputs SHALL be don't-care in every cycle except the start-sampling cycle.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE and clear all outputs to 0, including during LOAD, CHECK, ITER or FIX.
REQ-029 The aborted operation SHALL produce no done pulse.
REQ-030 reset SHALL take priority over start in the same cycle.

Structure
REQ-031 The shared package SHALL hold the FSM state encoding (3 bits, IDLE=0) and the width constants (16, 8, iteration count 8).
REQ-032 The design SHALL be split into a control FSM and one sub-module, div_datapath, which holds the operand and magnitude registers, the 9-bit subtractor, the counter and the sign fix.
REQ-033 div_datapath SHALL reuse the existing addsub and counter_down cells.

Verification
REQ-034 100 / 7 -> quotient=0x0E, remainder=0x02, flags 0, done exactly 11 edges after start.
REQ-035 -100 / 7 -> quotient=0xF2 (-14), remainder=0xFE (-2); 100 / -7 -> quotient=0xF2, remainder=0x02.
REQ-036 -1024 / 8 -> quotient=0x80, remainder=0, overflow=0; -1024 / -8 -> overflow=1, quotient=0, remainder=0.
REQ-037 1234 / 0 -> div_by_zero=1, done 2 edges after start.
REQ-038 32767 / 1 -> overflow=1 from CHECK.
REQ-039 Assert reset in the 4th ITER cycle -> all outputs 0, no done; a new 100 / 7 then completes correctly.
